// File: rtl/d_sramlike_bridge.sv
// ---------------------------------------------------------------------------
// d_sramlike_bridge
//
// Purpose:
//   Bridges the pipeline's memory-stage data port (single-cycle SRAM-style
//   access) onto the SoC's two-phase sram-like data bus. A request is issued
//   with req and accepted by addr_ok. The transaction then completes with
//   data_ok. While the access is outstanding, the block raises d_stall toward
//   the hazard unit. Returned read data is held stable until the whole
//   pipeline moves on.
//
// Parameters:
//   DW               data / address width (only 32 is supported)
//
// Ports:
//   i_clk            system clock, rising-edge active
//   i_rst_n          asynchronous active-low reset
//   i_data_en        memory-stage access valid
//   i_data_wen[3:0]  byte write strobes, 0000 = read
//   i_data_addr      byte address
//   i_data_wdata     byte-lane aligned write data
//   i_longest_stall  OR of every pipeline stall source (includes o_d_stall)
//   o_data_rdata     read word returned to the pipeline
//   o_d_stall        data-side stall request
//   o_req            bus request valid
//   o_wr             1 = write, 0 = read
//   o_size[1:0]      0 = byte, 1 = half, 2 = word
//   o_addr           bus address
//   o_wdata          bus write data
//   i_addr_ok        slave accepted the request
//   i_data_ok        slave completed the transaction
//   i_rdata          bus read data, valid only with i_data_ok
//
// Configuration:
//   D_BRIDGE_RDATA_BYPASS_EN  When defined, bus read data is forwarded
//                             combinationally in the data_ok cycle, and the
//                             stall is released one cycle earlier.
// ---------------------------------------------------------------------------
module d_sramlike_bridge #(
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_data_en,
    input  logic [3:0]    i_data_wen,
    input  logic [DW-1:0] i_data_addr,
    input  logic [DW-1:0] i_data_wdata,
    input  logic          i_longest_stall,
    output logic [DW-1:0] o_data_rdata,
    output logic          o_d_stall,
    output logic          o_req,
    output logic          o_wr,
    output logic [1:0]    o_size,
    output logic [DW-1:0] o_addr,
    output logic [DW-1:0] o_wdata,
    input  logic          i_addr_ok,
    input  logic          i_data_ok,
    input  logic [DW-1:0] i_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [DW-1:0] r_rdata_q;

    logic          w_req;
    logic          w_illegal_wen;
    logic          w_wr;
    logic [1:0]    w_size;
    logic          w_data_done;
    logic          w_stall_raw;

    // Strobe decode. A strobe pattern that is not a byte, an aligned half or
    // a full word cannot be expressed on the bus. It is issued as a harmless
    // word read rather than as a corrupting write.
    always_comb begin
        w_size        = 2'd2;
        w_illegal_wen = 1'b0;
        case (i_data_wen)
            4'b1111:                            w_size = 2'd2;
            4'b0011, 4'b1100:                   w_size = 2'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: w_size = 2'd0;
            4'b0000:                            w_size = 2'd2;
            default: begin
                w_size        = 2'd2;
                w_illegal_wen = 1'b1;
            end
        endcase
    end

    assign w_wr    = (|i_data_wen) & ~w_illegal_wen;
    assign o_wr    = w_wr;
    assign o_size  = w_size;
    assign o_wdata = i_data_wdata;

    // Reads always fetch the whole aligned word. The pipeline extracts the
    // byte or half it needs from the returned word.
    assign o_addr  = w_wr ? i_data_addr : {i_data_addr[DW-1:2], 2'b00};

    // The request is combinational from data_en, so the bus sees it in the
    // same cycle the memory stage presents the access.
    assign w_req       = ((r_state == S_IDLE) & i_data_en) | (r_state == S_ADDR);
    assign w_data_done = (r_state == S_DATA) & i_data_ok;

    // While reset is held, req and d_stall are forced low. This matters even
    // though the state is IDLE, because data_en may be high during reset.
    assign o_req = w_req & i_rst_n;

`ifdef D_BRIDGE_RDATA_BYPASS_EN
    // The completing cycle already has its data on the bus. The stall is
    // dropped and the bus word is forwarded, so the pipeline can advance now.
    assign w_stall_raw  = i_data_en & (r_state != S_DONE) & ~w_data_done;
    assign o_data_rdata = w_data_done ? i_rdata : r_rdata_q;
`else
    assign w_stall_raw  = i_data_en & (r_state != S_DONE);
    assign o_data_rdata = r_rdata_q;
`endif

    assign o_d_stall = w_stall_raw & i_rst_n;

    // Next-state logic. addr_ok only has meaning while a request is driven
    // (IDLE with data_en, or ADDR). data_ok only has meaning in DATA. Every
    // other case holds the current state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_data_en) begin
                    w_state_nxt = i_addr_ok ? S_DATA : S_ADDR;
                end
            end
            S_ADDR: begin
                if (i_addr_ok) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (i_data_ok) begin
`ifdef D_BRIDGE_RDATA_BYPASS_EN
                    // This block's own stall term is already masked here.
                    // A high longest_stall therefore means another stage is
                    // holding the pipeline, and the result must be kept.
                    w_state_nxt = i_longest_stall ? S_DONE : S_IDLE;
`else
                    w_state_nxt = S_DONE;
`endif
                end
            end
            S_DONE: begin
                // data_en stays high here until the pipeline advances. Staying
                // in DONE stops the same access from being reissued.
                if (!i_longest_stall) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register. An asynchronous reset abandons any transaction in
    // flight. The bus slave shares this reset, so no cleanup handshake is
    // needed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Read data capture. This also fires for writes, which keeps the enable
    // simple. The pipeline never consumes data_rdata for a store.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata_q <= '0;
        end else if (w_data_done) begin
            r_rdata_q <= i_rdata;
        end
    end

endmodule

// File: tb/tb_d_sramlike_bridge.sv
// ---------------------------------------------------------------------------
// tb_d_sramlike_bridge
//
// Directed bench for d_sramlike_bridge. Drives memory-stage accesses and acts
// as the bus slave, with configurable addr_ok / data_ok wait cycles and extra
// stall from other pipeline stages. Expected bus fields, stall lengths and
// read data are hand-computed constants given with each vector.
// ---------------------------------------------------------------------------
module tb_d_sramlike_bridge;

   logic        clk;
   logic        rstN;
   logic        dataEn;
   logic [3:0]  dataWen;
   logic [31:0] dataAddr;
   logic [31:0] dataWdata;
   logic        otherStall;
   logic        addrOk;
   logic        dataOk;
   logic [31:0] busRdata;

   logic [31:0] dataRdata;
   logic        dStall;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        longestStall;

   int vectorCount;
   int missCount;

   // The pipeline-wide stall includes the bridge's own request.
   assign longestStall = dStall | otherStall;

   d_sramlike_bridge #(.DW(32)) dut (
      .i_clk           (clk),
      .i_rst_n         (rstN),
      .i_data_en       (dataEn),
      .i_data_wen      (dataWen),
      .i_data_addr     (dataAddr),
      .i_data_wdata    (dataWdata),
      .i_longest_stall (longestStall),
      .o_data_rdata    (dataRdata),
      .o_d_stall       (dStall),
      .o_req           (req),
      .o_wr            (wr),
      .o_size          (size),
      .o_addr          (addr),
      .o_wdata         (wdata),
      .i_addr_ok       (addrOk),
      .i_data_ok       (dataOk),
      .i_rdata         (busRdata)
   );

   // Clock: rising edges at 5, 15, 25 ... Inputs change on the falling edge,
   // and outputs are sampled 3 time units later, before the next rising edge.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Global time limit, so the bench can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts the comparison and reports a mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Memory stage idle for n cycles.
   task automatic idleCycles(input int n);
      repeat (n) begin
         @(negedge clk);
         dataEn     = 1'b0;
         addrOk     = 1'b0;
         dataOk     = 1'b0;
         otherStall = 1'b0;
      end
   endtask

   // One complete access, from its first cycle up to the cycle where the
   // pipeline advances. data_en is left high so that a following call is a
   // back-to-back access.
   //   addrWait   : cycles of req before addr_ok
   //   dataWait   : wait cycles between the first DATA cycle and data_ok
   //   extraStall : cycles that other stages keep stalling after data_ok
   //   expStall   : d_stall cycles for the fully registered read path
   //                (one fewer when the read data is bypassed)
   task automatic applyStimulus(input string tag, input logic [3:0] wen,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, input int addrWait,
                                input int dataWait, input int extraStall,
                                input logic expWr, input logic [1:0] expSize,
                                input logic [31:0] expAddr, input int expStall);
      int dataCycle;
      int firstValid;
      int k;
      int reqCnt;
      int stallCnt;
      int addrChg;
      int rdBad;
      int stallTarget;
      bit released;
      dataCycle = addrWait + 1 + dataWait;
`ifdef D_BRIDGE_RDATA_BYPASS_EN
      firstValid  = dataCycle;
      stallTarget = expStall - 1;
`else
      firstValid  = dataCycle + 1;
      stallTarget = expStall;
`endif
      k        = 0;
      reqCnt   = 0;
      stallCnt = 0;
      addrChg  = 0;
      rdBad    = 0;
      released = 1'b0;
      while (!released && k < 64) begin
         @(negedge clk);
         dataEn     = 1'b1;
         dataWen    = wen;
         dataAddr   = a;
         dataWdata  = wd;
         addrOk     = (k == addrWait);
         dataOk     = (k == dataCycle);
         busRdata   = (k == dataCycle) ? rd : (32'h5A5A_0000 | k);
         otherStall = (extraStall > 0) && (k >= dataCycle) && (k <= dataCycle + extraStall);
         #3;
         if (k == 0) begin
            checkOutput({tag, "_req"},   req,   1'b1);
            checkOutput({tag, "_wr"},    wr,    expWr);
            checkOutput({tag, "_size"},  size,  expSize);
            checkOutput({tag, "_addr"},  addr,  expAddr);
            checkOutput({tag, "_wdata"}, wdata, wd);
         end
         if (req) reqCnt++;
         if (dStall) stallCnt++;
         if (addr !== expAddr) addrChg++;
         if (k >= firstValid && dataRdata !== rd) rdBad++;
         released = !(dStall | otherStall);
         k++;
      end
      checkOutput({tag, "_released"},  released, 1'b1);
      checkOutput({tag, "_reqCycles"}, reqCnt,   addrWait + 1);
      checkOutput({tag, "_stallCyc"},  stallCnt, stallTarget);
      checkOutput({tag, "_addrMoved"}, addrChg,  0);
      checkOutput({tag, "_rdataBad"},  rdBad,    0);
      checkOutput({tag, "_rdata"},     dataRdata, rd);
   endtask

   initial begin
      vectorCount = 0;
      missCount   = 0;
      rstN        = 1'b0;
      dataEn      = 1'b1;
      dataWen     = 4'b0000;
      dataAddr    = 32'h8000_0000;
      dataWdata   = 32'h0;
      addrOk      = 1'b0;
      dataOk      = 1'b0;
      busRdata    = 32'h0;
      otherStall  = 1'b0;

      // Reset state: while reset is held, req and d_stall stay low even with
      // data_en high.
      #23;
      checkOutput("rst_req",   req,       1'b0);
      checkOutput("rst_stall", dStall,    1'b0);
      checkOutput("rst_rdata", dataRdata, 32'h0);
      @(negedge clk);
      rstN   = 1'b1;
      dataEn = 1'b0;
      idleCycles(1);

      // Best-case word read.
      applyStimulus("rd0", 4'b0000, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF,
                    0, 0, 0, 1'b0, 2'd2, 32'h8000_0004, 2);
      idleCycles(1);

      // Byte write, lane 2: exactly one request is made.
      applyStimulus("wb", 4'b0100, 32'h8000_0012, 32'h00AB_0000, 32'h1111_2222,
                    0, 0, 0, 1'b1, 2'd0, 32'h8000_0012, 2);
      idleCycles(2);

      // Slow slave, unaligned read address: 3 addr waits and 1 data wait.
      applyStimulus("slow", 4'b0000, 32'h8000_0103, 32'h0, 32'h1234_5678,
                    3, 1, 0, 1'b0, 2'd2, 32'h8000_0100, 6);
      idleCycles(1);

      // Other stages stall 4 more cycles. The next access follows back to
      // back, so its immediate request shows the return to IDLE.
      applyStimulus("hold", 4'b0000, 32'h0000_0040, 32'h0, 32'hCAFE_F00D,
                    0, 0, 4, 1'b0, 2'd2, 32'h0000_0040, 2);
      applyStimulus("hold_next", 4'b0000, 32'h0000_0044, 32'h0, 32'h0BAD_C0DE,
                    0, 0, 0, 1'b0, 2'd2, 32'h0000_0044, 2);
      idleCycles(1);

      // Upper-half write, then a back-to-back read.
      applyStimulus("wh", 4'b1100, 32'h1000_0002, 32'hAABB_0000, 32'h7777_0000,
                    0, 0, 0, 1'b1, 2'd1, 32'h1000_0002, 2);
      applyStimulus("wh_rd", 4'b0000, 32'h1000_0008, 32'h0, 32'h0102_0304,
                    1, 0, 0, 1'b0, 2'd2, 32'h1000_0008, 3);
      idleCycles(1);

      // Lower-half write, a single top-byte write, then an unsupported strobe
      // pattern. The last must go out as an aligned word read.
      applyStimulus("wl", 4'b0011, 32'h3000_0000, 32'h0000_BEEF, 32'h2222_3333,
                    0, 2, 0, 1'b1, 2'd1, 32'h3000_0000, 4);
      applyStimulus("wb3", 4'b1000, 32'h3000_0003, 32'h9900_0000, 32'h4444_5555,
                    0, 0, 0, 1'b1, 2'd0, 32'h3000_0003, 2);
      applyStimulus("bad", 4'b0101, 32'h2000_0007, 32'h00CC_00DD, 32'h6666_7777,
                    0, 0, 0, 1'b0, 2'd2, 32'h2000_0004, 2);
      idleCycles(1);

      // Reset while a transaction is in DATA.
      @(negedge clk);
      dataEn   = 1'b1;
      dataWen  = 4'b0000;
      dataAddr = 32'h8000_0020;
      addrOk   = 1'b1;
      dataOk   = 1'b0;
      #3;
      checkOutput("mid_req_issued", req, 1'b1);
      @(negedge clk);
      addrOk = 1'b0;
      #2;
      checkOutput("mid_in_data_stall", dStall, 1'b1);
      checkOutput("mid_in_data_noreq", req,    1'b0);
      #1 rstN = 1'b0;
      #1;
      checkOutput("mid_rst_req",   req,       1'b0);
      checkOutput("mid_rst_stall", dStall,    1'b0);
      checkOutput("mid_rst_rdata", dataRdata, 32'h0);
      @(negedge clk);
      rstN   = 1'b1;
      dataEn = 1'b0;
      idleCycles(1);

      // After reset, a read completes normally from IDLE.
      applyStimulus("post_rst", 4'b0000, 32'h8000_0024, 32'h0, 32'hA5A5_5A5A,
                    0, 0, 0, 1'b0, 2'd2, 32'h8000_0024, 2);
      idleCycles(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
